// File: rtl/ball_motion.sv
// Ball position/motion controller: keyboard-steered ball that advances once per frame strobe,
// with a space-bar pause toggle. Define BALL_WRAP_EN to wrap at the play-field limits instead of bouncing.
module ball_motion #(
    parameter int X_CENTER = 320,
    parameter int Y_CENTER = 240,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479,
    parameter int STEP     = 1,
    parameter int SIZE     = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_size,
    output logic       paused
);

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam logic [9:0] STEP_POS = 10'(STEP);
    localparam logic [9:0] STEP_NEG = 10'(-STEP);

    logic       frame_clk_reg;
    logic [7:0] key_reg;
    logic [0:0] state_reg;
    logic [0:0] state_next;
    logic       frame_tick;
    logic       space_edge;
    logic       move_en;

    assign frame_tick = frame_clk & ~frame_clk_reg;
    assign space_edge = (keycode == KEY_SPACE) && (key_reg != KEY_SPACE);
    // A pause request arriving with the tick wins, so that tick never moves the ball.
    assign move_en    = frame_tick && (state_reg == RUN) && !space_edge;

    always_comb begin
        state_next = state_reg;
        if (space_edge) begin
            state_next = (state_reg == RUN) ? HOLD : RUN;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_reg <= 1'b0;
            key_reg       <= 8'h00;
            state_reg     <= RUN;
        end else begin
            frame_clk_reg <= frame_clk;
            key_reg       <= keycode;
            state_reg     <= state_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            // Axis 0 is X (A/D steer it, W/S zero it), axis 1 is Y (W/S steer it, A/D zero it).
            localparam int         AX_MIN    = (gi == 0) ? X_MIN : Y_MIN;
            localparam int         AX_MAX    = (gi == 0) ? X_MAX : Y_MAX;
            localparam int         AX_CENTER = (gi == 0) ? X_CENTER : Y_CENTER;
            localparam logic [7:0] NEG_KEY   = (gi == 0) ? KEY_A : KEY_W;
            localparam logic [7:0] POS_KEY   = (gi == 0) ? KEY_D : KEY_S;
            localparam logic [7:0] OFF_KEY0  = (gi == 0) ? KEY_W : KEY_A;
            localparam logic [7:0] OFF_KEY1  = (gi == 0) ? KEY_S : KEY_D;

            logic [9:0] pos_reg;
            logic [9:0] pos_next;
            logic [9:0] motion_reg;
            logic [9:0] motion_next;
            logic [9:0] key_motion;

            always_comb begin
                key_motion = motion_reg;
                if (keycode == NEG_KEY) begin
                    key_motion = STEP_NEG;
                end else if (keycode == POS_KEY) begin
                    key_motion = STEP_POS;
                end else if ((keycode == OFF_KEY0) || (keycode == OFF_KEY1)) begin
                    key_motion = '0;
                end
            end

`ifndef BALL_WRAP_EN
            logic [10:0] pos_hi;
            assign pos_hi = {1'b0, pos_reg} + 11'(SIZE);

            // Limit contact overrides the keyboard; the new direction is applied in the same tick.
            always_comb begin
                motion_next = key_motion;
                if (pos_hi >= 11'(AX_MAX)) begin
                    motion_next = STEP_NEG;
                end else if ({1'b0, pos_reg} <= 11'(AX_MIN + SIZE)) begin
                    motion_next = STEP_POS;
                end
                pos_next = pos_reg + motion_next;
            end
`else
            logic signed [11:0] sum_wide;
            assign sum_wide = $signed({2'b00, pos_reg}) + $signed({{2{key_motion[9]}}, key_motion});

            // Widened sum makes both overshoot and modulo underflow show up as out-of-range values.
            always_comb begin
                motion_next = key_motion;
                pos_next    = sum_wide[9:0];
                if (sum_wide > $signed(12'(AX_MAX))) begin
                    pos_next = 10'(AX_MIN);
                end else if (sum_wide < $signed(12'(AX_MIN))) begin
                    pos_next = 10'(AX_MAX);
                end
            end
`endif

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    pos_reg    <= 10'(AX_CENTER);
                    motion_reg <= '0;
                end else if (move_en) begin
                    pos_reg    <= pos_next;
                    motion_reg <= motion_next;
                end
            end
        end
    endgenerate

    assign BallX     = g_axis[0].pos_reg;
    assign BallY     = g_axis[1].pos_reg;
    assign Ball_size = 10'(SIZE);
    assign paused    = (state_reg == HOLD);

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed scenarios plus randomized stimulus
// compared every cycle against an integer reference model of the ball behaviour.
module tb_ball_motion;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] Ball_size;
    logic       paused;

    ball_motion dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .frame_clk(frame_clk),
        .keycode  (keycode),
        .BallX    (BallX),
        .BallY    (BallY),
        .Ball_size(Ball_size),
        .paused   (paused)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_x = 320, m_y = 240, m_mx = 0, m_my = 0;
    int m_paused = 0, m_prev_frame = 0, m_prev_key = 0;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int advance(input int p, input int m, input int lo, input int hi);
        int s;
        s = p + m;
`ifdef BALL_WRAP_EN
        if (s > hi) return lo;
        if (s < lo) return hi;
        return s;
`else
        return s & 1023;
`endif
    endfunction

    task automatic model_update(input logic rst, input logic fr, input logic [7:0] key);
        bit tick, sp;
        if (rst) begin
            m_x = 320; m_y = 240; m_mx = 0; m_my = 0;
            m_paused = 0; m_prev_frame = 0; m_prev_key = 0;
            return;
        end
        tick = fr && (m_prev_frame == 0);
        sp   = (key == 8'h2C) && (m_prev_key != 8'h2C);
        if (tick && !m_paused && !sp) begin
            case (key)
                8'h1A: begin m_my = -1; m_mx = 0; end
                8'h16: begin m_my = 1;  m_mx = 0; end
                8'h04: begin m_mx = -1; m_my = 0; end
                8'h07: begin m_mx = 1;  m_my = 0; end
                default: ;
            endcase
`ifndef BALL_WRAP_EN
            if (m_y + 4 >= 479) m_my = -1;
            else if (m_y <= 4)  m_my = 1;
            if (m_x + 4 >= 639) m_mx = -1;
            else if (m_x <= 4)  m_mx = 1;
`endif
            m_x = advance(m_x, m_mx, 0, 639);
            m_y = advance(m_y, m_my, 0, 479);
        end
        if (sp) m_paused = !m_paused;
        m_prev_frame = fr;
        m_prev_key   = key;
    endtask

    // One clock cycle: drive, clock, update model, compare away from the edge.
    task automatic step(input logic rst, input logic fr, input logic [7:0] key);
        Reset = rst; frame_clk = fr; keycode = key;
        @(posedge Clk);
        model_update(rst, fr, key);
        #1;
        check("ballx", int'(BallX), m_x);
        check("bally", int'(BallY), m_y);
        check("paused", int'(paused), m_paused);
        check("size", int'(Ball_size), 4);
    endtask

    // One frame: rising strobe cycle then a low cycle.
    task automatic frame(input logic [7:0] key);
        step(1'b0, 1'b1, key);
        step(1'b0, 1'b0, key);
    endtask

    int x0;
    int hit;
    logic [7:0] keys [7] = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C, 8'h55};

    initial begin
        // Reset state
        repeat (3) step(1'b1, 1'b0, 8'h00);
        check("rst_x", int'(BallX), 320);
        check("rst_y", int'(BallY), 240);
        check("rst_paused", int'(paused), 0);
        check("rst_size", int'(Ball_size), 4);
        $display("txn reset: BallX=%0d BallY=%0d paused=%0d", BallX, BallY, paused);

        // Idle frames: no movement
        repeat (10) frame(8'h00);
        check("idle_x", int'(BallX), 320);
        check("idle_y", int'(BallY), 240);
        $display("txn idle 10 frames: BallX=%0d BallY=%0d", BallX, BallY);

        // D held for 5 ticks, each update visible exactly one cycle after its tick
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h07);
            check("d_latency", int'(BallX), 321 + i);
            step(1'b0, 1'b0, 8'h07);
        end
        check("d5_x", int'(BallX), 325);
        check("d5_y", int'(BallY), 240);
        $display("txn D x5: BallX=%0d BallY=%0d", BallX, BallY);

`ifndef BALL_WRAP_EN
        // S held until the lower limit, then forced back up
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            frame(8'h16);
            if (BallY == 10'd475) hit = 1;
        end
        check("reach_475", int'(BallY), 475);
        frame(8'h16);
        check("bounce_474", int'(BallY), 474);
        $display("txn S bounce: BallY=%0d", BallY);
`else
        // D held until the right limit, then wrap to zero
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            frame(8'h07);
            if (BallX == 10'd639) hit = 1;
        end
        check("reach_639", int'(BallX), 639);
        frame(8'h07);
        check("wrap_0", int'(BallX), 0);
        $display("txn D wrap: BallX=%0d", BallX);
`endif

        // Pause: space held 100 cycles with strobes, position frozen
        step(1'b0, 1'b0, 8'h07);
        frame(8'h07);
        step(1'b0, 1'b0, 8'h00);
        x0 = int'(BallX);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, i[0], 8'h2C);
        end
        check("hold_paused", int'(paused), 1);
        check("hold_frozen", int'(BallX), x0);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h2C);
        check("resume_paused", int'(paused), 0);
        frame(8'h00);
        check("resume_motion", int'(BallX), model_x_expect(x0));
        $display("txn pause/resume: paused=%0d BallX=%0d", paused, BallX);

        // Reset on the same cycle as a tick with A pressed
        step(1'b0, 1'b0, 8'h04);
        step(1'b1, 1'b1, 8'h04);
        check("rst_tick_x", int'(BallX), 320);
        step(1'b0, 1'b0, 8'h00);
        frame(8'h00);
        check("rst_motion0", int'(BallX), 320);
        $display("txn reset+tick: BallX=%0d", BallX);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
                 keys[$urandom_range(0, 6)]);
        end
        $display("txn random 4000 cycles done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Expected X after one resumed frame: moves by the motion held before the pause.
    function automatic int model_x_expect(input int x_before);
`ifndef BALL_WRAP_EN
        return (x_before + 1) & 1023;
`else
        return (x_before + 1 > 639) ? 0 : x_before + 1;
`endif
    endfunction

endmodule
